uart_prog_loader: RTL and testbench



---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rx_byte.sv | 77 +++++++
 rtl/uart_prog_loader.sv | 105 ++++++++++
 tb/tb_uart_prog_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared RX/session state encodings and oversampling constants for the UART program loader
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} sess_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-flop rx synchronizer and 16x oversampling tick.
// With UART_LOADER_TIMEOUT_EN it also exports tick and rx_idle for the loader's inter-byte timeout.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 128_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stop_err
`ifdef UART_LOADER_TIMEOUT_EN
  ,
  output logic       tick,
  output logic       rx_idle
`endif
);
  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = DIV > 1 ? $clog2(DIV) : 1;
`ifndef UART_LOADER_TIMEOUT_EN
  logic tick;
`endif
  rx_state_t st, nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0] sync;
  logic [3:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] sh;
  logic rx_s, fall, mid, last;
  // sync[1] is the synchronized rx, sync[2] its previous value for edge detection
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= 3'b111;
    else sync <= {sync[1:0], rx};
  assign rx_s = sync[1];
  assign fall = sync[2] & ~rx_s;
  assign tick = div_cnt == DIV_W'(DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) div_cnt <= '0;
    else div_cnt <= tick ? '0 : div_cnt + 1'b1;
  assign mid  = tick && tcnt == 4'(MID_SAMPLE - 1);
  assign last = tick && tcnt == 4'(OVERSAMPLE - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= RX_IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      RX_IDLE:  nxt = fall ? RX_START : RX_IDLE;
      RX_START: nxt = mid ? (rx_s ? RX_IDLE : RX_BITS) : RX_START;
      RX_BITS:  nxt = last && &bcnt ? RX_STOP : RX_BITS;
      RX_STOP:  nxt = last ? RX_IDLE : RX_STOP;
      default:  nxt = RX_IDLE;
    endcase
  end
  always_comb begin
    byte_valid = st == RX_STOP && last && rx_s;
    stop_err   = st == RX_STOP && last && !rx_s;
    rx_byte    = sh;
`ifdef UART_LOADER_TIMEOUT_EN
    rx_idle    = st == RX_IDLE;
`endif
  end
  // tick phase restarts at mid start bit so later samples land mid-bit
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tcnt <= '0;
      bcnt <= '0;
      sh   <= '0;
    end else begin
      tcnt <= (st == RX_IDLE || (st == RX_START && mid)) ? '0 : tick ? tcnt + 1'b1 : tcnt;
      bcnt <= st == RX_IDLE ? '0 : (st == RX_BITS && last) ? bcnt + 1'b1 : bcnt;
      sh   <= (st == RX_BITS && last) ? {rx_s, sh[7:1]} : sh;
    end
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: loads a 32-bit word count then that many little-endian words over UART into a word-addressed memory.
// Optional inter-byte timeout enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_prog_loader
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 10_000_000,
  parameter int BAUD         = 128_000,
  parameter int ADDR_W       = 14,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);
  sess_state_t st, nxt;
  logic [7:0] rx_byte;
  logic byte_valid, stop_err, timeout, fin;
  logic [1:0] bidx;
  logic [31:0] word, n_words, widx, asm;
  logic active, word_done, in_range, restart;
`ifdef UART_LOADER_TIMEOUT_EN
  logic tick, rx_idle;
  logic [3:0] to_sub;
  logic [31:0] to_bits;
`endif
  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .stop_err   (stop_err)
`ifdef UART_LOADER_TIMEOUT_EN
    ,
    .tick       (tick),
    .rx_idle    (rx_idle)
`endif
  );
  assign active    = st == S_HDR || st == S_DATA;
  assign restart   = start && !active;
  assign word_done = active && byte_valid && &bidx;
  assign asm       = {rx_byte, word[31:8]};
  assign in_range  = (widx >> ADDR_W) == '0;
`ifdef UART_LOADER_TIMEOUT_EN
  // bit-time counter saturates at the limit and waits for the receiver to be idle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      to_sub  <= '0;
      to_bits <= '0;
    end else if (!active || byte_valid) begin
      to_sub  <= '0;
      to_bits <= '0;
    end else if (tick && to_bits < 32'(TIMEOUT_BITS)) begin
      to_sub  <= to_sub + 1'b1;
      to_bits <= to_bits + 32'(&to_sub);
    end
  assign timeout = to_bits >= 32'(TIMEOUT_BITS) && rx_idle;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= S_IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      S_HDR:   nxt = (stop_err || timeout) ? S_ERR : word_done ? (asm == '0 ? S_DONE : S_DATA) : S_HDR;
      S_DATA:  nxt = (stop_err || timeout) ? S_ERR : fin ? S_DONE : S_DATA;
      default: nxt = start ? S_HDR : st;
    endcase
  end
  always_comb begin
    busy      = active;
    done      = st == S_DONE;
    frame_err = st == S_ERR;
  end
  // fin lags the last word by one cycle so done follows the final write strobe
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bidx    <= '0;
      word    <= '0;
      n_words <= '0;
      widx    <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
      fin     <= 1'b0;
      wr_addr <= '0;
    end else begin
      bidx    <= restart ? '0 : (active && byte_valid) ? bidx + 1'b1 : bidx;
      word    <= (active && byte_valid) ? asm : word;
      n_words <= (st == S_HDR && word_done) ? asm : n_words;
      widx    <= restart ? '0 : (st == S_DATA && word_done) ? widx + 1'b1 : widx;
      wr_en   <= st == S_DATA && word_done && in_range;
      wr_data <= (st == S_DATA && word_done) ? asm : wr_data;
      fin     <= st == S_DATA && word_done && widx + 1'b1 == n_words;
      wr_addr <= restart ? '0 : (wr_en && !(&wr_addr)) ? wr_addr + 1'b1 : wr_addr;
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed and randomized load sessions checked against a word-list model of the loader.
module tb_uart_prog_loader;
  logic clk = 1'b0;
  logic reset, start, rx;
  logic wr_en, busy, done, frame_err;
  logic [3:0] wr_addr;
  logic [31:0] wr_data;
  int n_cmp = 0, n_bad = 0, cyc = 0, last_start = 0, done_cyc = -1, wr_cyc = -1;
  logic done_q = 1'b0;
  logic [3:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] q[$];
  logic [31:0] n, w0;

  always #5 clk = ~clk;

  uart_prog_loader #(.CLK_HZ(1_600_000), .BAUD(100_000), .ADDR_W(4), .TIMEOUT_BITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .rx(rx), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .frame_err(frame_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      wr_cyc = cyc;
    end
    if (done && !done_q) done_cyc = cyc;
    done_q = done;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    last_start = cyc;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] x);
    for (int k = 0; k < 4; k++) send_byte(x[8*k +: 8], 1'b1);
  endtask

  // model: header n, then words; the first min(n,16) words land at addresses 0..
  task automatic load(input string tag, input logic [31:0] cnt, input logic [31:0] w[$]);
    int nexp;
    wa.delete();
    wd.delete();
    done_cyc = -1;
    wr_cyc = -1;
    pulse_start();
    send_word(cnt);
    foreach (w[i]) send_word(w[i]);
    repeat (24) @(negedge clk);
    nexp = cnt > 16 ? 16 : int'(cnt);
    check({tag, "/nwr"}, 64'(wa.size()), 64'(nexp));
    for (int i = 0; i < nexp && i < wa.size(); i++) begin
      check($sformatf("%s/addr%0d", tag, i), 64'(wa[i]), 64'(i));
      check($sformatf("%s/data%0d", tag, i), 64'(wd[i]), 64'(w[i]));
    end
    check({tag, "/done"}, 64'(done), 64'd1);
    check({tag, "/busy"}, 64'(busy), 64'd0);
    check({tag, "/ferr"}, 64'(frame_err), 64'd0);
    if (cnt >= 1 && cnt <= 16) check({tag, "/done_after_wr"}, 64'(done_cyc - wr_cyc), 64'd1);
    else check({tag, "/done_lat"}, 64'((done_cyc - last_start) inside {[150:160]}), 64'd1);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("rst/wr_en", 64'(wr_en), 64'd0);
    check("rst/wr_addr", 64'(wr_addr), 64'd0);
    check("rst/wr_data", 64'(wr_data), 64'd0);
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/done", 64'(done), 64'd0);
    check("rst/ferr", 64'(frame_err), 64'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    q.delete();
    q.push_back(32'h1122_3344);
    q.push_back(32'hDEAD_BEEF);
    load("basic", 32'd2, q);

    q.delete();
    load("empty", 32'd0, q);

    wa.delete();
    pulse_start();
    check("ferr/busy_start", 64'(busy), 64'd1);
    send_word(32'd1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b0);
    repeat (24) @(negedge clk);
    check("ferr/ferr", 64'(frame_err), 64'd1);
    check("ferr/busy", 64'(busy), 64'd0);
    check("ferr/nwr", 64'(wa.size()), 64'd0);
    pulse_start();
    check("ferr/cleared", 64'(frame_err), 64'd0);
    check("ferr/rebusy", 64'(busy), 64'd1);
    send_word(32'd0);
    repeat (24) @(negedge clk);
    check("ferr/recover_done", 64'(done), 64'd1);

    pulse_start();
    @(negedge clk) rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch/busy", 64'(busy), 64'd1);
    check("glitch/done", 64'(done), 64'd0);
    check("glitch/ferr", 64'(frame_err), 64'd0);
    q.delete();
    q.push_back($urandom);
    load("glitch", 32'd1, q);

    q.delete();
    for (int i = 0; i < 17; i++) q.push_back($urandom);
    load("n17", 32'd17, q);

    for (int r = 0; r < 3; r++) begin
      n = 32'($urandom_range(1, 6));
      q.delete();
      for (int i = 0; i < int'(n); i++) q.push_back($urandom);
      load($sformatf("rand%0d", r), n, q);
    end

    wa.delete();
    wd.delete();
    w0 = $urandom;
    pulse_start();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (80) @(negedge clk);
`ifdef UART_LOADER_TIMEOUT_EN
    check("tmo/ferr", 64'(frame_err), 64'd1);
    check("tmo/busy", 64'(busy), 64'd0);
`else
    check("tmo/busy", 64'(busy), 64'd1);
    check("tmo/ferr", 64'(frame_err), 64'd0);
`endif
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(w0);
    repeat (24) @(negedge clk);
`ifdef UART_LOADER_TIMEOUT_EN
    check("tmo/nwr", 64'(wa.size()), 64'd0);
    check("tmo/done", 64'(done), 64'd0);
`else
    check("tmo/nwr", 64'(wa.size()), 64'd1);
    if (wd.size() > 0) check("tmo/data", 64'(wd[0]), 64'(w0));
    check("tmo/done", 64'(done), 64'd1);
`endif

    wa.delete();
    pulse_start();
    send_word(32'd2);
    send_byte(8'h77, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h55, 1'b1);
    @(negedge clk) rx = 1'b0;
    repeat (60) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst/wr_en", 64'(wr_en), 64'd0);
    check("arst/wr_addr", 64'(wr_addr), 64'd0);
    check("arst/busy", 64'(busy), 64'd0);
    check("arst/done", 64'(done), 64'd0);
    check("arst/ferr", 64'(frame_err), 64'd0);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    reset = 1'b1;
    repeat (200) @(negedge clk);
    check("arst/nwr", 64'(wa.size()), 64'd0);
    check("arst/idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
